quick_spi_arbiter: RTL and testbench

//  Shares one quick_spi master among NUM_REQUESTERS clients using round-robin arbitration.

---
 rtl/quick_spi_defs_pkg.sv | 26 ++
 rtl/quick_spi_rr_pick.sv | 34 +++
 rtl/quick_spi_arbiter.sv | 120 ++++++++++++
 tb/tb_quick_spi_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_defs_pkg.sv
// Shared definitions for the quick_spi master and its request arbiter:
// state encodings, default widths and a constant-friendly clog2.
package quick_spi_defs;

  localparam int DEFAULT_OUTGOING_DATA_WIDTH = 16;
  localparam int DEFAULT_NUMBER_OF_SLAVES    = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_SEL = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_DONE     = 3'd4
  } arb_state_t;

  // Never returns less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/quick_spi_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQUESTERS.
module quick_spi_rr_pick
  import quick_spi_defs::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int PTR_WIDTH      = clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [PTR_WIDTH-1:0]      ptr,
  output logic                      valid,
  output logic [PTR_WIDTH-1:0]      idx,
  output logic [NUM_REQUESTERS-1:0] onehot
);

  logic [PTR_WIDTH-1:0] cand;

  // Walk from farthest to nearest so the closest hit to ptr is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      cand = PTR_WIDTH'((int'(ptr) + i) % NUM_REQUESTERS);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) onehot = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi master among several clients;
// completion is inferred from the master's ss_n select/release sequence.
module quick_spi_arbiter
  import quick_spi_defs::*;
#(
  parameter int NUM_REQUESTERS      = 4,
  parameter int OUTGOING_DATA_WIDTH = DEFAULT_OUTGOING_DATA_WIDTH,
  parameter int NUMBER_OF_SLAVES    = DEFAULT_NUMBER_OF_SLAVES,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [NUM_REQUESTERS-1:0]                     req,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]                     grant,
  output logic [NUM_REQUESTERS-1:0]                     done,
  output logic                                          timeout_err,
  output logic                                          busy,
  output logic                                          spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
  output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
  input  logic [NUMBER_OF_SLAVES-1:0]                   spi_ss_n
);

  localparam int PW = clog2(NUM_REQUESTERS);
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYCLES);

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        idx;
  logic [CW-1:0]        cnt;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [NUM_REQUESTERS-1:0] pick_onehot;
  logic                 ss_idle;

  assign ss_idle = (spi_ss_n == '1);

  quick_spi_rr_pick #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .PTR_WIDTH     (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx),
    .onehot(pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      ptr                   <= '0;
      idx                   <= '0;
      cnt                   <= '0;
      grant                 <= '0;
      done                  <= '0;
      timeout_err           <= 1'b0;
      busy                  <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_outgoing_data     <= '0;
    end else begin
      spi_start_transaction <= 1'b0;
      done                  <= '0;
      timeout_err           <= 1'b0;
      if ((state == ST_WAIT_SEL || state == ST_WAIT_REL) && cnt != CNT_SAT)
        cnt <= cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant                 <= pick_onehot;
            idx                   <= pick_idx;
            spi_slave             <= req_slave[pick_idx*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
            spi_outgoing_data     <= req_data[pick_idx*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
            spi_start_transaction <= 1'b1;
            busy                  <= 1'b1;
            state                 <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT_SEL;
        end
        // A master that never selects (e.g. was busy and ignored start) ends here via timeout.
        ST_WAIT_SEL: begin
          if (cnt >= CNT_LAST) begin
            done        <= grant;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else if (!ss_idle) begin
            state <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (ss_idle) begin
            done  <= grant;
            state <= ST_DONE;
          end else if (cnt >= CNT_LAST) begin
            done        <= grant;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (idx == PW'(NUM_REQUESTERS - 1)) ? '0 : idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Randomized bench for quick_spi_arbiter with a transaction-level round-robin
// model and a simple ss_n-driving master stand-in.
module tb_quick_spi_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int TO = 24;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*S-1:0] req_slave;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           timeout_err;
  logic           busy;
  logic           spi_start_transaction;
  logic [S-1:0]   spi_slave;
  logic [W-1:0]   spi_outgoing_data;
  logic [S-1:0]   spi_ss_n;

  int total_count;
  int bad_count;
  int model_ptr;

  quick_spi_arbiter #(
    .NUM_REQUESTERS     (N),
    .OUTGOING_DATA_WIDTH(W),
    .NUMBER_OF_SLAVES   (S),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .req_slave            (req_slave),
    .req_data             (req_data),
    .grant                (grant),
    .done                 (done),
    .timeout_err          (timeout_err),
    .busy                 (busy),
    .spi_start_transaction(spi_start_transaction),
    .spi_slave            (spi_slave),
    .spi_outgoing_data    (spi_outgoing_data),
    .spi_ss_n             (spi_ss_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic scrambleClientInputs();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W]  = W'($urandom);
      req_slave[i*S +: S] = S'($urandom);
    end
  endtask

  // Round-robin rule: first requesting client at or after model_ptr, modulo N.
  function automatic int modelPick(input logic [N-1:0] r);
    int winner;
    winner = -1;
    for (int k = N - 1; k >= 0; k--)
      if (r[(model_ptr + k) % N]) winner = (model_ptr + k) % N;
    return winner;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_start"}, 32'(spi_start_transaction), 32'd0);
  endtask

  // Entered on a falling edge with the arbiter visibly idle; runs one full transaction.
  task automatic applyStimulus(input logic [N-1:0] req_v, input int ss_delay, input int ss_len,
                               input bit drop, input bit expect_timeout);
    int           exp_idx;
    int           waited;
    logic [W-1:0] exp_data;
    logic [S-1:0] exp_slave;
    logic [S-1:0] ss_low;
    req = req_v;
    scrambleClientInputs();
    exp_idx   = modelPick(req_v);
    exp_data  = req_data[exp_idx*W +: W];
    exp_slave = req_slave[exp_idx*S +: S];
    ss_low    = S'($urandom_range(0, (1 << S) - 2));

    @(negedge clk);
    checkOutput("grant", 32'(grant), 32'(1) << exp_idx);
    checkOutput("start_high", 32'(spi_start_transaction), 32'd1);
    checkOutput("busy", 32'(busy), 32'd1);
    checkOutput("data_latched", 32'(spi_outgoing_data), 32'(exp_data));
    checkOutput("slave_latched", 32'(spi_slave), 32'(exp_slave));
    scrambleClientInputs();

    @(negedge clk);
    checkOutput("start_one_cycle", 32'(spi_start_transaction), 32'd0);
    checkOutput("grant_hold", 32'(grant), 32'(1) << exp_idx);
    if (drop) req[exp_idx] = 1'b0;

    if (expect_timeout) begin
      waited = 1;
      while (done == '0 && waited < TO + 8) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("timeout_latency", 32'(waited), 32'(TO + 1));
      checkOutput("timeout_err", 32'(timeout_err), 32'd1);
    end else begin
      for (int c = 0; c < ss_delay; c++) begin
        checkOutput("no_early_done", 32'(done), 32'd0);
        @(negedge clk);
      end
      spi_ss_n = ss_low;
      for (int c = 0; c < ss_len; c++) begin
        @(negedge clk);
        checkOutput("no_done_while_sel", 32'(done), 32'd0);
        checkOutput("data_stable", 32'(spi_outgoing_data), 32'(exp_data));
      end
      spi_ss_n = '1;
      @(negedge clk);
      checkOutput("no_timeout_err", 32'(timeout_err), 32'd0);
    end
    checkOutput("done_pulse", 32'(done), 32'(1) << exp_idx);
    checkOutput("grant_in_done", 32'(grant), 32'(1) << exp_idx);
    model_ptr = (exp_idx + 1) % N;

    @(negedge clk);
    checkIdle("after_done");
    checkOutput("err_cleared", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    total_count = 0;
    bad_count   = 0;
    model_ptr   = 0;
    reset_n     = 1'b0;
    req         = '0;
    req_slave   = '0;
    req_data    = '0;
    spi_ss_n    = '1;

    repeat (3) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_data", 32'(spi_outgoing_data), 32'd0);
    checkOutput("reset_slave", 32'(spi_slave), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // All clients requesting continuously: served 0,1,2,3,0.
    for (int t = 0; t < 5; t++) applyStimulus(4'b1111, 1, 2, 1'b0, 1'b0);

    applyStimulus(4'b0010, 0, 1, 1'b0, 1'b0);
    applyStimulus(4'b0011, 2, 3, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1, 2, 1'b0, 1'b0);

    // Client withdraws mid-transaction: completes, then no regrant.
    applyStimulus(4'b1000, 2, 2, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdle("no_regrant");
    end

    for (int t = 0; t < 16; t++)
      applyStimulus(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
                    $urandom_range(1, 4), 1'b0, 1'b0);

    applyStimulus(4'b0001, 0, 0, 1'b0, 1'b1);

    // Reset while the master has the slave selected.
    req = 4'b0100;
    @(negedge clk);
    checkOutput("pre_reset_grant", 32'(grant), 32'h4);
    @(negedge clk);
    spi_ss_n = 2'b10;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkIdle("mid_reset");
    checkOutput("mid_reset_data", 32'(spi_outgoing_data), 32'd0);
    reset_n   = 1'b1;
    spi_ss_n  = '1;
    req       = '0;
    model_ptr = 0;
    @(negedge clk);
    applyStimulus(4'b1111, 1, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
